// File: rtl/myproject_layernorm_var_accum.sv
// ---------------------------------------------------------------------------
// myproject_layernorm_var_accum
//
// Sums N_ELEM = 2**LOG2_N signed squared-deviation products per row and emits
// the row variance (sum >> LOG2_N, truncated, saturated to OUT_WIDTH bits).
// Negative products are clamped to zero and flag the row as erroneous; in_last
// is only checked against the internal beat count, never used for framing.
// A single result register holds the variance; while it is being handed off,
// in_ready follows out_ready so the next row can start without a bubble.
//
// Ports
//   ap_clk     clock, rising edge
//   ap_rst_n   asynchronous active-low reset
//   in_valid   product beat valid
//   in_ready   block accepts a beat this cycle
//   in_data    signed product (x-mean)^2
//   in_last    producer marks final element of row (checked only)
//   out_valid  variance valid
//   out_ready  consumer accepts variance
//   out_data   unsigned saturated variance
//   out_err    row framing/sign error, qualified by out_valid
// ---------------------------------------------------------------------------
module myproject_layernorm_var_accum #(
    parameter int unsigned PROD_WIDTH = 32,
    parameter int unsigned LOG2_N     = 4,
    parameter int unsigned OUT_WIDTH  = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_err
);

    // Extra LOG2_N bits make the sum of N_ELEM non-negative products overflow-free.
    localparam int unsigned AccWidth = PROD_WIDTH + LOG2_N;
    localparam int unsigned NElem    = 1 << LOG2_N;
    localparam int unsigned CntWidth = (LOG2_N > 0) ? LOG2_N : 1;

    typedef enum logic {
        StAccum,
        StOutput
    } state_e;

    state_e                state_q, state_d;
    logic [AccWidth-1:0]   acc_q, acc_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_err_q, out_err_d;

    logic                  accept;
    logic                  neg;
    logic                  row_end;
    logic                  last_bad;
    logic [AccWidth-1:0]   addend;
    logic [AccWidth-1:0]   acc_next;
    logic                  err_next;
    logic [PROD_WIDTH-1:0] var_full;
    logic [OUT_WIDTH-1:0]  var_sat;

    always_comb begin
        // Handoff cycle: a beat may enter only when the held result leaves.
        in_ready  = (state_q == StAccum) | out_ready;
        out_valid = (state_q == StOutput);
        out_data  = out_data_q;
        out_err   = out_err_q;

        accept   = in_valid & in_ready;
        neg      = in_data[PROD_WIDTH-1];
        addend   = neg ? '0 : AccWidth'(in_data);
        row_end  = (cnt_q == CntWidth'(NElem - 1));
        last_bad = in_last ^ row_end;
        acc_next = acc_q + addend;
        err_next = err_q | neg | last_bad;

        var_full = PROD_WIDTH'(acc_next >> LOG2_N);
        var_sat  = (|var_full[PROD_WIDTH-1:OUT_WIDTH]) ? '1 : var_full[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;

        if (state_q == StOutput && out_ready) begin
            state_d = StAccum;
        end

        if (accept) begin
            if (row_end) begin
                out_data_d = var_sat;
                out_err_d  = err_next;
                acc_d      = '0;
                cnt_d      = '0;
                err_d      = 1'b0;
                state_d    = StOutput;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + CntWidth'(1);
                err_d = err_next;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StAccum;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_myproject_layernorm_var_accum.sv
// ---------------------------------------------------------------------------
// tb_myproject_layernorm_var_accum
//
// Directed rows plus 1000 randomised rows. Accepted beats feed a row-level
// reference model that pushes expected (variance, err) pairs into a queue; a
// monitor pops and compares on every output handshake and checks that the
// held result stays stable while the consumer stalls.
// ---------------------------------------------------------------------------
module tb_myproject_layernorm_var_accum;

    localparam int NE = 16;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_err;

    myproject_layernorm_var_accum #(
        .PROD_WIDTH(32),
        .LOG2_N    (4),
        .OUT_WIDTH (24)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [23:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
    logic [31:0] rv[NE];
    int          lastp = NE - 1;

    // Reference model state: running row sum of clamped products.
    longint      m_sum = 0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          expect_valid_next = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Consumer ready generator.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference model: observes accepted beats, frames rows by count.
    initial begin
        exp_t e;
        longint v;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                m_sum = 0;
                m_cnt = 0;
                m_err = 1'b0;
                expect_valid_next = 1'b0;
            end else begin
                if (expect_valid_next) check("latency_out_valid", 64'(out_valid), 64'd1);
                expect_valid_next = 1'b0;
                if (in_valid && in_ready) begin
                    if ($signed(in_data) < 0) m_err = 1'b1;
                    else m_sum += longint'(in_data);
                    if (in_last != (m_cnt == NE - 1)) m_err = 1'b1;
                    m_cnt++;
                    if (m_cnt == NE) begin
                        v = m_sum / NE;
                        e.data = (v > 64'hFFFFFF) ? 24'hFFFFFF : 24'(v);
                        e.err  = m_err;
                        exp_q.push_back(e);
                        m_sum = 0;
                        m_cnt = 0;
                        m_err = 1'b0;
                        expect_valid_next = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: handshake checks, scoreboard pop, stall stability.
    initial begin
        exp_t        e;
        bit          prev_stall = 1'b0;
        logic [23:0] prev_data = '0;
        logic        prev_err = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid) check("in_ready_follows_out_ready", 64'(in_ready), 64'(out_ready));
                else if (!in_ready) check("in_ready_when_idle", 64'(in_ready), 64'd1);
                if (prev_stall) begin
                    check("stall_valid_held", 64'(out_valid), 64'd1);
                    check("stall_data_held", 64'(out_data), 64'(prev_data));
                    check("stall_err_held", 64'(out_err), 64'(prev_err));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("out_err", 64'(out_err), 64'(e.err));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_err   = out_err;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input bit gaps);
        bit got;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = $urandom_range(0, 1);
                @(posedge ap_clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        got = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge ap_clk);
            got = in_ready;
            @(posedge ap_clk);
            #1;
        end
        if (!got) check("accept_timeout", 64'(got), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_row(input bit gaps);
        for (int i = 0; i < NE; i++) send_beat(rv[i], (i == lastp), gaps);
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < NE; i++) rv[i] = v;
        lastp = NE - 1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge ap_clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int r;
        // Reset state.
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_err", 64'(out_err), 64'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // T1: constant row.
        fill(32'd100);
        send_row(1'b0);
        drain();

        // T2: ramp 0..15, truncating shift.
        for (int i = 0; i < NE; i++) rv[i] = 32'(i);
        lastp = NE - 1;
        send_row(1'b0);
        drain();

        // T3: saturation, then a small row.
        fill(32'h7FFF_FFFF);
        send_row(1'b0);
        fill(32'd1);
        send_row(1'b0);
        drain();

        // T4: consumer stalls, next row queued behind it.
        ready_mode = 0;
        fill(32'd3);
        send_row(1'b0);
        fill(32'd8);
        fork
            send_row(1'b0);
            begin
                repeat (6) @(posedge ap_clk);
                #1;
                ready_mode = 1;
            end
        join
        drain();

        // T5: negative beat and early in_last, then a clean row.
        fill(32'd16);
        rv[3] = 32'hFFFF_FFFB;
        lastp = 6;
        send_row(1'b0);
        fill(32'd16);
        send_row(1'b0);
        drain();

        // T6: reset mid-row discards partial state.
        fill(32'd50);
        for (int i = 0; i < 8; i++) send_beat(rv[i], 1'b0, 1'b0);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        check("midrow_reset_out_valid", 64'(out_valid), 64'd0);
        ap_rst_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("no_stale_output", 64'(out_valid), 64'd0);
        send_row(1'b0);
        drain();

        // Random rows with producer gaps and consumer stalls.
        ready_mode = 2;
        for (int row = 0; row < 1000; row++) begin
            for (int i = 0; i < NE; i++) begin
                r = $urandom_range(0, 99);
                if (r < 2) rv[i] = 32'h8000_0000 | $urandom;
                else if (r < 8) rv[i] = 32'h4000_0000 | ($urandom & 32'h7FFF_FFFF);
                else rv[i] = $urandom_range(0, 100000);
            end
            lastp = ($urandom_range(0, 19) == 0) ? $urandom_range(0, NE - 1) : NE - 1;
            send_row(1'b1);
        end
        ready_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
